// File: rtl/imem_arbiter_wires.sv
// Shared types for the instruction-side memory arbiter: memory request/response
// records, arbiter state and the register record with its reset value.
package imem_arbiter_wires;

    localparam int burst_max = 4;
    localparam int cnt_width = $clog2(burst_max) + 1;
    localparam logic [cnt_width-1:0] burst_limit = cnt_width'(burst_max);

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_type;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_sel_type;

    typedef struct packed {
        arb_state_type        state;
        port_sel_type         owner;
        port_sel_type         ptr;
        logic                 lock;
        logic [cnt_width-1:0] cnt;
        mem_in_type           req;
    } arb_reg_type;

    localparam arb_reg_type arb_reg_init = '{
        state: IDLE,
        owner: PORT_I,
        ptr:   PORT_I,
        lock:  1'b0,
        cnt:   '0,
        req:   '0
    };

    function automatic port_sel_type other_port(input port_sel_type p);
        return (p == PORT_I) ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/imem_arb_select.sv
// Winner selection for the memory arbiter: a held burst lock beats everything,
// then a lone requester, then the round-robin pointer.
module imem_arb_select
    import imem_arbiter_wires::*;
(
    input  logic         ivalid,
    input  logic         dvalid,
    input  logic         lock,
    input  port_sel_type owner,
    input  port_sel_type ptr,
    output port_sel_type winner,
    output logic         any,
    output logic         keep_lock
);

    logic owner_valid;

    always_comb begin
        owner_valid = (owner == PORT_I) ? ivalid : dvalid;
        keep_lock   = lock && owner_valid;
        any         = ivalid || dvalid;

        if (keep_lock) begin
            winner = owner;
        end else if (ivalid && dvalid) begin
            winner = ptr;
        end else if (dvalid) begin
            winner = PORT_D;
        end else begin
            winner = PORT_I;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of one instruction-side memory port. One transaction
// in flight, round-robin between ports, refill bursts kept together by a lock.
module imem_arbiter
    import imem_arbiter_wires::*;
(
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  ireq_in,
    output mem_out_type ireq_out,
    input  mem_in_type  dreq_in,
    output mem_out_type dreq_out,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);

    arb_reg_type          r;
    arb_reg_type          rin;
    port_sel_type         winner;
    logic                 any;
    logic                 keep_lock;
    logic                 done;
    logic [cnt_width-1:0] cnt_inc;

    imem_arb_select u_select (
        .ivalid    (ireq_in.mem_valid),
        .dvalid    (dreq_in.mem_valid),
        .lock      (r.lock),
        .owner     (r.owner),
        .ptr       (r.ptr),
        .winner    (winner),
        .any       (any),
        .keep_lock (keep_lock)
    );

    assign done    = (r.state == BUSY) && mem_out.mem_ready;
    assign cnt_inc = r.cnt + 1'b1;

    // The latched request is cleared on completion, so mem_in is idle in IDLE.
    always_comb begin
        rin = r;
        case (r.state)
            IDLE: begin
                if (!keep_lock) begin
                    rin.lock = 1'b0;
                    rin.cnt  = '0;
                end
                if (any) begin
                    rin.state = BUSY;
                    rin.owner = winner;
                    rin.req   = (winner == PORT_I) ? ireq_in : dreq_in;
                end
            end
            BUSY: begin
                if (mem_out.mem_ready) begin
                    rin.state = IDLE;
                    rin.req   = '0;
                    if (!r.req.mem_fence && (cnt_inc < burst_limit)) begin
                        rin.lock = 1'b1;
                        rin.cnt  = cnt_inc;
                    end else begin
                        rin.lock = 1'b0;
                        rin.cnt  = '0;
                        rin.ptr  = other_port(r.owner);
                    end
                end
            end
            default: begin
                rin = arb_reg_init;
            end
        endcase
    end

    always_comb begin
        ireq_out = '0;
        dreq_out = '0;
        if (done) begin
            if (r.owner == PORT_I) begin
                ireq_out.mem_rdata = mem_out.mem_rdata;
                ireq_out.mem_ready = 1'b1;
            end else begin
                dreq_out.mem_rdata = mem_out.mem_rdata;
                dreq_out.mem_ready = 1'b1;
            end
        end
    end

    assign mem_in = r.req;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r <= arb_reg_init;
        end else begin
            r <= rin;
        end
    end

endmodule
